// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS-lite datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and stalls on memory ready.
module multicycle_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop2,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NORI  = 6'b001110;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  state_t state_q;
  state_t state_n;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  assign state = state_q;

  // Memory handshake: a request (memread/memwrite) is held steady in FETCH,
  // MEMRD and MEMWR; the access completes in the cycle mem_ready is high, and
  // only then does the FSM advance. Reset masks every control output.
  always_comb begin
    state_n     = FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop2      = 1'b0;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_n = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXEC;
          OP_BEQ:       state_n = BRANCH;
          OP_J:         state_n = JUMP;
          OP_NORI:      state_n = IEXEC;
          default: begin
            state_n = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_n = MEMRD;
        else if (op == OP_SW) state_n = MEMWR;
        else                  state_n = FETCH;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_n = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_n  = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
        state_n = RWB;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop1  = 1'b1;
        aluop0  = 1'b1;
        state_n = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
      end
      default: state_n = FETCH;
    endcase

    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsource    = 2'b00;
      aluop1      = 1'b0;
      aluop0      = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule
